mul16_seq_ctrl: RTL

- Sequencer for the 16-cycle shift-and-add unsigned multiplier.
- Accepts one operand pair through a valid/ready handshake and latches the operands.
- Steps a 4-bit step index 0..15. Each step adds the multiplicand into a 16-bit overlapping window of the 32-bit accumulator, conditional on the selected multiplier bit.
- Holds the 32-bit product with out_valid until the consumer takes it.

---
 rtl/mul16_pkg.sv | 15 +
 rtl/acc_window_mux.sv | 13 +
 rtl/mul16_seq_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/mul16_pkg.sv
// Shared types and constants for the 16x16 sequential shift-and-add multiplier.
package mul16_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          OP_W      = 16;
    localparam int          PROD_W    = 32;
    localparam int          STEP_W    = 4;
    localparam logic [3:0]  LAST_STEP = 4'd15;

endpackage

// File: rtl/acc_window_mux.sv
// Selects the 16-bit accumulator window acc[step+15:step] that the current step adds into.
module acc_window_mux
    import mul16_pkg::*;
(
    input  logic [PROD_W-1:0] acc,
    input  logic [STEP_W-1:0] step,
    output logic [OP_W-1:0]   window
);

    // step never exceeds 15, so the slice stays inside acc[30:0]
    assign window = acc[step +: OP_W];

endmodule

// File: rtl/mul16_seq_ctrl.sv
// Sequencer for a 16-step shift-and-add unsigned multiplier with valid/ready
// handshakes on the operand and product sides.
module mul16_seq_ctrl
    import mul16_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b0,
    parameter int WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic [STEP_W-1:0]    step
);

    state_t              state_r;
    logic [OP_W-1:0]     a_r;
    logic [OP_W-1:0]     b_r;
    logic [PROD_W-1:0]   acc_r;
    logic [STEP_W-1:0]   step_r;
    logic                in_ready_r;
    logic                out_valid_r;
    logic                busy_r;

    logic [OP_W-1:0]     window_s;
    logic [OP_W-1:0]     addend_s;
    logic [OP_W:0]       sum_s;
    logic [PROD_W-1:0]   mask_s;
    logic [PROD_W-1:0]   wdata_s;
    logic [PROD_W-1:0]   acc_next_s;
    logic                upper_zero_s;
    logic                finish_s;

    acc_window_mux u_window (
        .acc    (acc_r),
        .step   (step_r),
        .window (window_s)
    );

    // Step datapath: 17-bit sum written back through a bit-enable mask over acc[step+16:step]
    always_comb begin
        addend_s     = b_r[step_r] ? a_r : 16'd0;
        sum_s        = {1'b0, window_s} + {1'b0, addend_s};
        mask_s       = 32'h0001_FFFF << step_r;
        wdata_s      = {15'd0, sum_s} << step_r;
        acc_next_s   = (acc_r & ~mask_s) | (wdata_s & mask_s);
        upper_zero_s = ((b_r >> ({1'b0, step_r} + 5'd1)) == 16'd0);
        finish_s     = (step_r == LAST_STEP) || (EARLY_EXIT && upper_zero_s);
    end

    // Control FSM with registered handshake/status outputs and the accumulator
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            a_r         <= 16'd0;
            b_r         <= 16'd0;
            acc_r       <= 32'd0;
            step_r      <= 4'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        a_r        <= a;
                        b_r        <= b;
                        acc_r      <= 32'd0;
                        step_r     <= 4'd0;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= RUN;
                    end
                end
                RUN: begin
                    acc_r <= acc_next_s;
                    if (finish_s) begin
                        step_r      <= 4'd0;
                        busy_r      <= 1'b0;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        step_r <= step_r + 4'd1;
                    end
                end
                DONE: begin
                    // in_ready only rises after the hand-off edge: no same-cycle bypass
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    step_r      <= 4'd0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign step      = step_r;
    assign product   = acc_r;

endmodule
